wb_fifo_slave: RTL and testbench
================================

// Module: wb_fifo_slave
// PURPOSE
//  Wishbone classic slave: an 8-bit-wide byte FIFO behind a 2-bit register map.
//  It is the responder side of the single-master Wishbone bus, in the same slot as the ROM slaves.
//  The master pushes bytes by writing DATA and pops them by reading DATA.
//  Status, flags, a threshold and an interrupt let the master pace transfers without polling every byte.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, 2..128
//  AW     4   log2(DEPTH); pointer width (count is AW+1 bits)
//  DW     8   data width; must equal bus width (8)
// PORTS
//  wb_clk_i  in   1   clock, all logic on rising edge
//  wb_rst_i  in   1   reset, synchronous, active-low (0 = reset)
//  wb_cyc_i  in   1   bus cycle valid
//  wb_stb_i  in   1   strobe, this slave selected
//  wb_we_i   in   1   1 = write, 0 = read
//  wb_adr_i  in   2   register address
//  wb_dat_i  in   8   write data
//  wb_dat_o  out  8   read data, valid while wb_ack_o = 1
//  wb_ack_o  out  1   cycle acknowledge
//  irq_o     out  1   level interrupt: count >= THRESH and THRESH != 0
// BEHAVIOUR
//  Reset (wb_rst_i = 0 at a clock edge):
//   - wb_ack_o = 0, wb_dat_o = 0x00, irq_o = 0.
//   - Pointers = 0, count = 0, OVF = UNF = 0, THRESH = 0x00.
//   - An in-flight cycle is dropped without ack; the master must restart it.
//  Handshake:
//   - req = cyc & stb & ~ack. On req, wb_ack_o is registered high for exactly 1 cycle (latency 1).
//   - Side effects (push/pop/flag updates) happen once, on the req edge.
//   - Back-to-back cycles therefore ack at most every other clock.
//  Register map:
//   - 0 DATA: write pushes wb_dat_i. Read pops the head; wb_dat_o = head byte.
//   - 1 COUNT (RO): wb_dat_o = zero-extended count (0..DEPTH). Writes are acked and ignored.
//   - 2 FLAGS: read = {4'b0, OVF, UNF, full, empty}.
//     Write: bit0 = 1 flushes (pointers, count -> 0); bit1 = 1 clears OVF and UNF. Bit0 and bit1 may be set together.
//   - 3 THRESH (RW): 8 bits; values > DEPTH mean irq_o never asserts.
//  Boundaries:
//   - Push when full: data dropped, count unchanged, OVF set (sticky).
//   - Pop when empty: wb_dat_o = 0x00, pointers unchanged, UNF set (sticky).
//   - Pointers wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
//   - One bus access per ack, so push and pop are never simultaneous.
//   - Flush during full or empty clears the state; sticky flags are unchanged unless bit1 is also set.
//   - irq_o is registered and reflects count after the update: it rises/falls 1 cycle after the causing ack edge.
//  Reads of data/status are combinational from state into the registered wb_dat_o, captured on the req edge.
// STRUCTURE
//  Package wb_fifo_pkg:
//   - Address constants ADR_DATA = 2'd0, ADR_COUNT = 2'd1, ADR_FLAGS = 2'd2, ADR_THRESH = 2'd3.
//   - FLAGS bit positions FLG_EMPTY = 0, FLG_FULL = 1, FLG_UNF = 2, FLG_OVF = 3.
//   - Control bit positions CTL_FLUSH = 0, CTL_CLR = 1.
//  Sub-module sync_fifo_core (DEPTH, AW, DW):
//   - Ports push, pop, flush, din, dout, count, full, empty.
//   - Register-array storage, ignores push-on-full and pop-on-empty.
//  Top level holds bus decode, ack generation, sticky flags, THRESH and irq_o.
// TESTING
//  1. Reset: hold wb_rst_i = 0 for 4 clocks -> ack = 0, dat_o = 0x00, irq = 0; reads of COUNT = 0x00 and FLAGS = 0x01.
//  2. Write DATA 0xA5, 0x3C, then read DATA twice -> returns 0xA5 then 0x3C; each ack is 1 cycle wide, 1 cycle after stb.
//  3. Push 17 bytes 0x00..0x10 with DEPTH = 16 -> COUNT = 0x10, FLAGS = 0x0A (OVF, full); reads return 0x00..0x0F.
//  4. Read DATA when empty -> 0x00 returned, FLAGS = 0x05; write FLAGS 0x02 -> FLAGS = 0x01.
//  5. THRESH = 3; push 3 bytes -> irq_o rises 1 cycle after the 3rd ack; pop 1 byte -> irq_o falls.
//  6. Push 5, write FLAGS 0x01 -> COUNT = 0. Separately, assert reset mid-cycle (stb high) -> no ack, state cleared.

Source files
------------

// File: rtl/wb_fifo_pkg.sv
// Shared constants for the Wishbone byte FIFO slave.
// Register addresses and bit positions of the FLAGS register.
package wb_fifo_pkg;
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_COUNT  = 2'd1;
  localparam logic [1:0] ADR_FLAGS  = 2'd2;
  localparam logic [1:0] ADR_THRESH = 2'd3;

  localparam int FLG_EMPTY = 0;
  localparam int FLG_FULL  = 1;
  localparam int FLG_UNF   = 2;
  localparam int FLG_OVF   = 3;

  localparam int CTL_FLUSH = 0;
  localparam int CTL_CLR   = 1;
endpackage

// File: rtl/sync_fifo_core.sv
// Register-array synchronous FIFO with flush.
// Push-on-full and pop-on-empty are ignored.
module sync_fifo_core #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic slave exposing a byte FIFO behind four registers.
// Holds bus decode, registered ack/data, sticky flags, THRESH and irq.
module wb_fifo_slave
  import wb_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          irq_o
);
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [DW-1:0] thresh_q, thresh_d;
  logic          irq_q, irq_d;

  logic          req, wr, rd;
  logic          push, pop, flush, clr;
  logic [DW-1:0] fifo_dout, rdata;
  logic [AW:0]   count;
  logic          full, empty;

  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr    = req & wb_we_i;
  assign rd    = req & ~wb_we_i;
  assign push  = wr && (wb_adr_i == ADR_DATA);
  assign pop   = rd && (wb_adr_i == ADR_DATA);
  assign flush = wr && (wb_adr_i == ADR_FLAGS) && wb_dat_i[CTL_FLUSH];
  assign clr   = wr && (wb_adr_i == ADR_FLAGS) && wb_dat_i[CTL_CLR];

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_core (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wb_dat_i),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rdata = '0;
    unique case (wb_adr_i)
      ADR_DATA:   rdata = empty ? '0 : fifo_dout;
      ADR_COUNT:  rdata = DW'(count);
      ADR_FLAGS:  rdata = {{(DW-4){1'b0}}, ovf_q, unf_q, full, empty};
      ADR_THRESH: rdata = thresh_q;
    endcase
  end

  always_comb begin
    ack_d    = req;
    dat_d    = dat_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    thresh_d = thresh_q;
    if (rd) dat_d = rdata;
    if (clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push && full) ovf_d = 1'b1;
    if (pop && empty) unf_d = 1'b1;
    if (wr && (wb_adr_i == ADR_THRESH)) thresh_d = wb_dat_i;
    // Uses the already-updated count, so irq lags the ack by a cycle.
    irq_d = (thresh_q != '0) && (DW'(count) >= thresh_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed bench for wb_fifo_slave with hand-computed expectations.
// Drives Wishbone classic cycles and checks data, flags, ack and irq.
module tb_wb_fifo_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cyc = 1'b0;
  logic       stb = 1'b0;
  logic       we  = 1'b0;
  logic [1:0] adr = 2'd0;
  logic [7:0] di  = 8'h00;
  logic [7:0] dout;
  logic       ack;
  logic       irq;

  int errors = 0;
  int checks = 0;
  int lat;
  logic got;
  logic [7:0] rv;

  wb_fifo_slave #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (di),
    .wb_dat_o (dout),
    .wb_ack_o (ack),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [1:0] a,
                     input logic [7:0] d, output logic [7:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; di = d;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    r = dout;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    bus(1'b1, a, d, unused);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] r);
    bus(1'b0, a, 8'h00, r);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", 32'(dout), 32'h00);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    idle();
    rd(2'd1, rv); chk("rst_count", 32'(rv), 32'h00);
    rd(2'd2, rv); chk("rst_flags", 32'(rv), 32'h01);

    idle();
    wr(2'd0, 8'hA5);
    chk("t2_lat", 32'(lat), 32'd1);
    idle();
    chk("t2_ack_width", 32'(ack), 32'd0);
    wr(2'd0, 8'h3C);
    idle();
    rd(2'd0, rv); chk("t2_rd0", 32'(rv), 32'hA5);
    idle();
    rd(2'd0, rv); chk("t2_rd1", 32'(rv), 32'h3C);
    chk("t2_rd_lat", 32'(lat), 32'd1);
    idle();
    chk("t2_rd_ack_width", 32'(ack), 32'd0);

    for (int i = 0; i <= 16; i++) wr(2'd0, 8'(i));
    rd(2'd1, rv); chk("t3_count", 32'(rv), 32'h10);
    rd(2'd2, rv); chk("t3_flags", 32'(rv), 32'h0A);
    for (int i = 0; i < 16; i++) begin
      rd(2'd0, rv);
      chk($sformatf("t3_pop%0d", i), 32'(rv), 32'(i));
    end
    rd(2'd2, rv); chk("t3_flags_empty", 32'(rv), 32'h09);
    wr(2'd2, 8'h02);

    rd(2'd0, rv); chk("t4_unf_data", 32'(rv), 32'h00);
    rd(2'd2, rv); chk("t4_flags_unf", 32'(rv), 32'h05);
    wr(2'd2, 8'h02);
    rd(2'd2, rv); chk("t4_flags_clr", 32'(rv), 32'h01);

    wr(2'd3, 8'h03);
    rd(2'd3, rv); chk("t5_thresh", 32'(rv), 32'h03);
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    idle();
    chk("t5_irq_lo2", 32'(irq), 32'd0);
    wr(2'd0, 8'h33);
    chk("t5_irq_at_ack", 32'(irq), 32'd0);
    idle();
    chk("t5_irq_rise", 32'(irq), 32'd1);
    rd(2'd0, rv);
    chk("t5_pop_data", 32'(rv), 32'h11);
    chk("t5_irq_at_pop", 32'(irq), 32'd1);
    idle();
    chk("t5_irq_fall", 32'(irq), 32'd0);

    wr(2'd3, 8'h11);
    for (int i = 0; i < 16; i++) wr(2'd0, 8'hF0);
    idle();
    chk("t5_irq_big_thresh", 32'(irq), 32'd0);
    wr(2'd2, 8'h01);
    rd(2'd1, rv); chk("t6_flush_count", 32'(rv), 32'h00);
    rd(2'd2, rv); chk("t6_flush_flags", 32'(rv), 32'h09);

    wr(2'd2, 8'h03);
    wr(2'd3, 8'h02);
    for (int i = 0; i < 5; i++) wr(2'd0, 8'(i + 8'h40));
    wr(2'd2, 8'h01);
    rd(2'd1, rv); chk("t6_flush5_count", 32'(rv), 32'h00);
    wr(2'd0, 8'h77);
    wr(2'd0, 8'h78);
    rd(2'd1, rv); chk("t6_pre_rst_count", 32'(rv), 32'h02);
    idle();
    chk("t6_pre_rst_irq", 32'(irq), 32'd1);

    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
    rst = 1'b0;
    idle();
    chk("t6_rst_noack0", 32'(ack), 32'd0);
    idle();
    chk("t6_rst_noack1", 32'(ack), 32'd0);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_dat", 32'(dout), 32'h00);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    idle();
    rd(2'd1, rv); chk("t6_rst_count", 32'(rv), 32'h00);
    rd(2'd2, rv); chk("t6_rst_flags", 32'(rv), 32'h01);
    rd(2'd3, rv); chk("t6_rst_thresh", 32'(rv), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
